// File: rtl/vga_timing_gen_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants, derived totals/sync bounds and FSM states
package vga_timing_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
  localparam bit DEF_SYNC_POL = 1'b0;
  localparam int DEF_PIPE_DELAY = 1;
  function automatic logic [9:0] total10(int a, int b, int c, int d);
    return 10'(a + b + c + d);
  endfunction
  function automatic logic [9:0] sync_start(int active, int fp);
    return 10'(active + fp);
  endfunction
  function automatic logic [9:0] sync_end(int active, int fp, int width);
    return 10'(active + fp + width - 1);
  endfunction
  localparam logic [9:0] H_TOTAL = total10(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam logic [9:0] V_TOTAL = total10(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
  localparam logic [9:0] HS_START = sync_start(DEF_H_ACTIVE, DEF_H_FP);
  localparam logic [9:0] HS_END = sync_end(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC);
  localparam logic [9:0] VS_START = sync_start(DEF_V_ACTIVE, DEF_V_FP);
  localparam logic [9:0] VS_END = sync_end(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC);
  typedef enum logic {PRIME, RUN} state_t;
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster position, blank and sync bundle fed to the pixel renderers
interface vga_timing_gen_if;
  logic [9:0] DrawX, DrawY;
  logic blank, hs, vs;
  logic hs_aligned, vs_aligned, blank_aligned;
  logic line_start, frame_start;
  logic [15:0] frame_count;
  modport master(output DrawX, DrawY, blank, hs, vs, hs_aligned, vs_aligned, blank_aligned,
                 line_start, frame_start, frame_count);
  modport slave(input DrawX, DrawY, blank, hs, vs, hs_aligned, vs_aligned, blank_aligned,
                line_start, frame_start, frame_count);
endinterface

// File: rtl/vga_timing_gen_sync_delay_line.sv
// sync_delay_line: DEPTH-stage shift register with a per-bit reset value
module sync_delay_line #(
  parameter int DEPTH = 1,
  parameter int W = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] sr [DEPTH];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= RST_VAL;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters with registered blank/sync decode and renderer-aligned copies
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  parameter bit SYNC_POL = DEF_SYNC_POL,
  parameter int PIPE_DELAY = DEF_PIPE_DELAY
) (
  input logic              vga_clk,
  input logic              reset,
  vga_timing_gen_if.master vif
);
  localparam logic [9:0] HT = total10(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam logic [9:0] VT = total10(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [9:0] HA = 10'(H_ACTIVE);
  localparam logic [9:0] VA = 10'(V_ACTIVE);
  localparam logic [9:0] HSS = sync_start(H_ACTIVE, H_FP);
  localparam logic [9:0] HSE = sync_end(H_ACTIVE, H_FP, H_SYNC);
  localparam logic [9:0] VSS = sync_start(V_ACTIVE, V_FP);
  localparam logic [9:0] VSE = sync_end(V_ACTIVE, V_FP, V_SYNC);
  localparam logic IDLE = ~SYNC_POL;
  state_t state, state_n;
  logic [9:0] hc, vc, hc_n, vc_n;
  logic blank, hs, vs, line_start, frame_start;
  logic blank_n, hs_n, vs_n, ls_n, fs_n, h_wrap;
  logic [15:0] frame_count;
  logic [2:0] aligned;
  // decode from next-state counters so registered outputs match DrawX/DrawY in the same cycle
  always_comb begin
    state_n = RUN;
    h_wrap = hc == HT - 10'd1;
    hc_n = (state == PRIME || h_wrap) ? '0 : hc + 10'd1;
    vc_n = (state == PRIME || (h_wrap && vc == VT - 10'd1)) ? '0 : h_wrap ? vc + 10'd1 : vc;
    blank_n = hc_n < HA && vc_n < VA;
    hs_n = (hc_n >= HSS && hc_n <= HSE) ? SYNC_POL : IDLE;
    vs_n = (vc_n >= VSS && vc_n <= VSE) ? SYNC_POL : IDLE;
    ls_n = hc_n == '0;
    fs_n = ls_n && vc_n == '0;
  end
  always_ff @(posedge vga_clk or posedge reset)
    if (reset) state <= PRIME;
    else state <= state_n;
  always_ff @(posedge vga_clk or posedge reset)
    if (reset) begin
      hc <= '0;
      vc <= '0;
      blank <= 1'b0;
      hs <= IDLE;
      vs <= IDLE;
      line_start <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      hc <= hc_n;
      vc <= vc_n;
      blank <= blank_n;
      hs <= hs_n;
      vs <= vs_n;
      line_start <= ls_n;
      frame_start <= fs_n;
      frame_count <= frame_count + 16'(fs_n && state == RUN);
    end
  sync_delay_line #(
    .DEPTH(PIPE_DELAY),
    .W(3),
    .RST_VAL({IDLE, IDLE, 1'b0})
  ) u_delay (
    .clk(vga_clk),
    .rst(reset),
    .d({hs, vs, blank}),
    .q(aligned)
  );
  assign vif.DrawX = hc;
  assign vif.DrawY = vc;
  assign vif.blank = blank;
  assign vif.hs = hs;
  assign vif.vs = vs;
  assign vif.line_start = line_start;
  assign vif.frame_start = frame_start;
  assign vif.frame_count = frame_count;
  assign {vif.hs_aligned, vif.vs_aligned, vif.blank_aligned} = aligned;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: random-reset bench comparing two raster configurations against a cycle-index model
module tb_vga_timing_gen;
  typedef struct {int ha, hfp, hsy, hbp, va, vfp, vsy, vbp, d; bit pol;} tm_t;
  typedef struct packed {
    logic [9:0] x, y;
    logic blank, hs, vs, ls, fs;
    logic [15:0] fc;
    logic hsa, vsa, ba;
  } obs_t;
  logic clk = 0, reset = 1;
  int total = 0, bad = 0, t = -1;
  tm_t m0 = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0};
  tm_t m1 = '{8, 2, 3, 2, 6, 1, 2, 1, 3, 1'b1};
  obs_t a0, a1;
  vga_timing_gen_if v0();
  vga_timing_gen_if v1();
  vga_timing_gen #(.PIPE_DELAY(2)) d0 (.vga_clk(clk), .reset(reset), .vif(v0));
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1), .PIPE_DELAY(3)
  ) d1 (.vga_clk(clk), .reset(reset), .vif(v1));
  assign a0 = {v0.DrawX, v0.DrawY, v0.blank, v0.hs, v0.vs, v0.line_start, v0.frame_start,
               v0.frame_count, v0.hs_aligned, v0.vs_aligned, v0.blank_aligned};
  assign a1 = {v1.DrawX, v1.DrawY, v1.blank, v1.hs, v1.vs, v1.line_start, v1.frame_start,
               v1.frame_count, v1.hs_aligned, v1.vs_aligned, v1.blank_aligned};
  always #5 clk = ~clk;
  // t = edges since reset release; the first edge after release is t = 0
  always @(posedge clk or posedge reset)
    if (reset) t <= -1;
    else t <= t + 1;
  function automatic obs_t base(tm_t m, int c);
    obs_t o;
    int ht, vt, x, y;
    o = '0;
    o.hs = ~m.pol;
    o.vs = ~m.pol;
    if (c >= 0) begin
      ht = m.ha + m.hfp + m.hsy + m.hbp;
      vt = m.va + m.vfp + m.vsy + m.vbp;
      x = c % ht;
      y = (c / ht) % vt;
      o.x = 10'(x);
      o.y = 10'(y);
      o.blank = x < m.ha && y < m.va;
      o.hs = (x >= m.ha + m.hfp && x < m.ha + m.hfp + m.hsy) ? m.pol : ~m.pol;
      o.vs = (y >= m.va + m.vfp && y < m.va + m.vfp + m.vsy) ? m.pol : ~m.pol;
      o.ls = x == 0;
      o.fs = x == 0 && y == 0;
      o.fc = 16'(c / (ht * vt));
    end
    return o;
  endfunction
  function automatic obs_t model(tm_t m, int c);
    obs_t o, p;
    o = base(m, c);
    p = base(m, c - m.d);
    o.hsa = p.hs;
    o.vsa = p.vs;
    o.ba = p.blank;
    return o;
  endfunction
  task automatic test_reset();
    obs_t e0, e1;
    repeat ($urandom_range(50, 700)) @(negedge clk);
    #($urandom_range(1, 3));
    reset = 1;
    #1;
    e0 = model(m0, -1);
    e1 = model(m1, -1);
    total += 2;
    if (a0 !== e0) begin bad++; $display("FAIL reset_async_d0 got=%h exp=%h", a0, e0); end
    if (a1 !== e1) begin bad++; $display("FAIL reset_async_d1 got=%h exp=%h", a1, e1); end
    repeat ($urandom_range(2, 5)) @(negedge clk);
    total += 2;
    if (a0 !== e0) begin bad++; $display("FAIL reset_hold_d0 got=%h exp=%h", a0, e0); end
    if (a1 !== e1) begin bad++; $display("FAIL reset_hold_d1 got=%h exp=%h", a1, e1); end
    reset = 0;
    @(negedge clk);
    total += 3;
    if (a0 !== model(m0, t)) begin bad++; $display("FAIL first_edge_d0 got=%h exp=%h", a0, model(m0, t)); end
    if (a1 !== model(m1, t)) begin bad++; $display("FAIL first_edge_d1 got=%h exp=%h", a1, model(m1, t)); end
    if ({a0.x, a0.y, a0.blank, a0.fs, a0.fc} !== {10'd0, 10'd0, 1'b1, 1'b1, 16'd0}) begin
      bad++;
      $display("FAIL first_edge_fields got x=%0d y=%0d blank=%b fs=%b fc=%0d exp 0 0 1 1 0",
               a0.x, a0.y, a0.blank, a0.fs, a0.fc);
    end
  endtask
  task automatic test_horizontal();
    int hw = 0, first_hs = -1, ba_fall = -1, ls_cnt = 0;
    logic prev_ba = 0;
    for (int i = 0; i < 1700; i++) begin
      total++;
      if (a0 !== model(m0, t)) begin bad++; $display("FAIL horiz_cycle t=%0d got=%h exp=%h", t, a0, model(m0, t)); end
      if (t < 800 && a0.hs == 1'b0) hw++;
      if (a0.hs == 1'b0 && first_hs < 0) first_hs = a0.x;
      if (prev_ba && !a0.ba && ba_fall < 0) ba_fall = a0.x;
      if (a0.ls) ls_cnt++;
      prev_ba = a0.ba;
      @(negedge clk);
    end
    total += 4;
    if (hw != 96) begin bad++; $display("FAIL hs_width got=%0d exp=96", hw); end
    if (first_hs != 656) begin bad++; $display("FAIL hs_start got=%0d exp=656", first_hs); end
    if (ba_fall != 642) begin bad++; $display("FAIL blank_aligned_fall got=%0d exp=642", ba_fall); end
    if (ls_cnt != 3) begin bad++; $display("FAIL line_start_count got=%0d exp=3", ls_cnt); end
  endtask
  task automatic test_frames();
    int vs_cnt = 0, wraps = 0;
    logic [9:0] px = 0, py = 0;
    for (int i = 0; i < 450; i++) begin
      total++;
      if (a1 !== model(m1, t)) begin bad++; $display("FAIL frame_cycle t=%0d got=%h exp=%h", t, a1, model(m1, t)); end
      if (a1.vs == 1'b1) vs_cnt++;
      if (px == 10'd14 && py == 10'd9) begin
        wraps++;
        total++;
        if ({a1.x, a1.y, a1.fs} !== {10'd0, 10'd0, 1'b1}) begin
          bad++;
          $display("FAIL frame_wrap got x=%0d y=%0d fs=%b exp 0 0 1", a1.x, a1.y, a1.fs);
        end
      end
      px = a1.x;
      py = a1.y;
      @(negedge clk);
    end
    total += 2;
    if (vs_cnt != 90) begin bad++; $display("FAIL vs_active_cycles got=%0d exp=90", vs_cnt); end
    if (wraps != 3) begin bad++; $display("FAIL wrap_count got=%0d exp=3", wraps); end
  endtask
  task automatic test_fc_wrap();
    logic [15:0] exp_fc [2] = '{16'hFFFF, 16'h0000};
    int n;
    @(negedge clk);
    force d1.frame_count = 16'hFFFE;
    @(negedge clk);
    release d1.frame_count;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      @(negedge clk);
      while (!a1.fs && n < 200) begin @(negedge clk); n++; end
      total++;
      if (!a1.fs || a1.fc !== exp_fc[k]) begin
        bad++;
        $display("FAIL fc_wrap_%0d got fs=%b fc=%h exp fs=1 fc=%h", k, a1.fs, a1.fc, exp_fc[k]);
      end
    end
  endtask
  task automatic test_random_resets();
    for (int r = 0; r < 3; r++) begin
      test_reset();
      repeat ($urandom_range(200, 400)) begin
        total += 2;
        if (a0 !== model(m0, t)) begin bad++; $display("FAIL rand_d0 t=%0d got=%h exp=%h", t, a0, model(m0, t)); end
        if (a1 !== model(m1, t)) begin bad++; $display("FAIL rand_d1 t=%0d got=%h exp=%h", t, a1, model(m1, t)); end
        @(negedge clk);
      end
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    reset = 0;
    test_reset();
    test_horizontal();
    test_frames();
    test_fc_wrap();
    test_random_resets();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the 640x480@60 Hz raster that drives every pixel renderer in the HDMI text/sprite controller: horizontal/vertical counters, DrawX/DrawY, active-video `blank`, and sync pulses. Also emits pipeline-aligned copies of sync and `blank` so the sync signals reaching the HDMI encoder line up with the registered pixel colour from the renderers. These renderers do a negedge ROM read, then a posedge colour register. Sits between the pixel clock domain root and all background/sprite renderers.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, H_SYNC, 96, H_BP, 48, horizontal porches/sync (total 800)
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, V_SYNC, 2, V_BP, 33, vertical porches/sync (total 525)
- `SYNC_POL`, 0, sync active level (0 = active-low)
- `PIPE_DELAY`, 1, renderer latency in vga_clk cycles (1..4)

- `vga_clk`  in  1  pixel clock; one pixel per rising edge
- `reset`  in  1  asynchronous, active-high
- `DrawX`  out  10  current column, 0..799
- `DrawY`  out  10  current line, 0..524
- `blank`  out  1  1 = active video (DrawX<640 and DrawY<480)
- `hs`, `vs`  out  1  syncs, same cycle as DrawX/DrawY
- `hs_aligned`, `vs_aligned`, `blank_aligned`  out  1  hs/vs/blank delayed PIPE_DELAY cycles
- `line_start`  out  1  pulse when DrawX==0
- `frame_start`  out  1  pulse when DrawX==0 and DrawY==0
- `frame_count`  out  16  completed-frame counter

## Operation
- FSM: PRIME, RUN. Reset forces PRIME.
- **PRIME**: counters held at (0,0). The first edge after reset release loads the decoded outputs for (0,0), then the FSM goes to RUN.
- **RUN**: hc increments each edge. At 799, hc wraps to 0 and vc increments. At vc=524 with hc=799, both wrap to 0.
- All outputs are registered and consistent with DrawX/DrawY in the same cycle. Decode uses next-state counters.
- Sync decode:
  - hs active for 656 ≤ DrawX ≤ 751
  - vs active for 490 ≤ DrawY ≤ 491
  - Boundaries are derived from the parameters, never hard-coded.
- `frame_count` increments by 1 in the cycle `frame_start` asserts, except the first frame after reset. Wraps 65535→0.
- Aligned outputs come from a shift register of depth PIPE_DELAY. Every stage resets to its inactive value: sync = ~SYNC_POL, blank = 0.
- Width rule: counter compares are 10-bit unsigned. Totals are computed in the package as 10-bit constants and must be < 1024.

## Timing
- Reset values:
  - DrawX = DrawY = 0
  - blank = 0
  - hs = vs = hs_aligned = vs_aligned = ~SYNC_POL
  - blank_aligned = 0
  - line_start = frame_start = 0
  - frame_count = 0
- First edge after release: DrawX=0, DrawY=0, blank=1, line_start=1, frame_start=1, frame_count stays 0.
- The aligned signals trail their sources by exactly PIPE_DELAY edges.
- Frame period is 420000 cycles; line period is 800 cycles.
- Reset mid-frame: the next cycle shows reset values immediately (asynchronous). Restart behaves exactly as after power-up. The delay line is flushed.

## Structure
- Package `vga_timing_pkg`:
  - default timing constants
  - derived H_TOTAL/V_TOTAL
  - sync start/end
  - `state_t` enum (PRIME, RUN)
- Sub-module `sync_delay_line`: parameterised depth and width, with a per-bit reset value. It carries {hs, vs, blank}.

## Test plan
- **Reset**: assert reset mid-line. Check all reset values. Release; after 1 edge, check DrawX=0, DrawY=0, blank=1, frame_start=1.
- **Horizontal**: on line 0, blank falls at DrawX=640. hs goes low at 656 and high at 752, a 96-cycle width. line_start fires every 800 cycles.
- **Vertical**: vs is low only during lines 490–491, i.e. 1600 cycles. blank=0 throughout lines 480–524.
- **Wrap**: at (799,524) the next cycle is (0,0) with frame_start=1, and frame_count goes 0→1 after one full frame. Force the counter near 65535 to check the wrap to 0.
- **Alignment**: with PIPE_DELAY=2, hs_aligned equals hs from 2 cycles earlier. blank_aligned falls at DrawX=642.
- **Polarity**: with SYNC_POL=1, hs is high for 656–751 and the reset value of hs/vs is 0.
